obi_mem_arbiter: RTL
====================

# obi_mem_arbiter

Two-to-one OBI arbiter that lets the core's instruction port and data port share a single OBI memory port. It sits between the core and the single-port memory/peripheral model in the core testbench. It arbitrates round-robin and keeps the downstream request stable until it is granted. It also tracks outstanding transactions in order, so every response returns to the requester that issued it.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (≥1, power of two)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- instr_req_i  in  1  instruction request
- instr_addr_i  in  ADDR_WIDTH  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  DATA_WIDTH  instruction read data
- data_req_i  in  1  data request
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  data write enable
- data_be_i  in  DATA_WIDTH/8  data byte enables
- data_wdata_i  in  DATA_WIDTH  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  DATA_WIDTH  data read data
- mem_req_o  out  1  downstream request
- mem_addr_o  out  ADDR_WIDTH  downstream address
- mem_we_o  out  1  downstream write enable (0 for instr)
- mem_be_o  out  DATA_WIDTH/8  downstream byte enables (all ones for instr)
- mem_wdata_o  out  DATA_WIDTH  downstream write data (0 for instr)
- mem_gnt_i  in  1  downstream grant
- mem_rvalid_i  in  1  downstream response valid
- mem_rdata_i  in  DATA_WIDTH  downstream read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count
- err_o  out  1  sticky: rvalid received with no outstanding transaction

## Operation
- State: `IDLE` (no selection held) and `LOCKED` (mem_req_o high, not yet granted; selection frozen).
- IDLE: if any request is pending and count < MAX_OUTSTANDING, select a requester.
  - Only one requesting: select it.
  - Both requesting: select the one not granted last (`last_grant` register; reset value = instr, so data wins the first conflict).
- A selection drives mem_req_o=1 and muxes that requester's fields onto mem_*.
  - mem_gnt_i=1 in the same cycle: transaction accepted and state stays IDLE.
  - mem_gnt_i=0: go to LOCKED.
- LOCKED: selection held regardless of the other requester; leave to IDLE on mem_gnt_i.
- Requests are not withdrawn before grant (OBI rule). Withdrawal is not a supported case.
- instr_gnt_o/data_gnt_o = mem_gnt_i & mem_req_o & selected(port); the unselected port's grant stays 0.
- On accepted grant: push port ID into an in-order ID FIFO (depth MAX_OUTSTANDING), update last_grant, count++.
- On mem_rvalid_i with count>0: pop the FIFO head, assert the head port's rvalid_o with rdata = mem_rdata_i, count--.
- Push and pop in the same cycle: count unchanged; FIFO read/write pointers both advance, with wrap-around at MAX_OUTSTANDING.
- Full (count == MAX_OUTSTANDING): mem_req_o=0, no grants, until a response pops. A pop in the same cycle does not unblock that cycle.
- mem_rvalid_i with count==0: no rvalid_o asserted, err_o set, and err_o holds until reset.
- rdata_o of the non-responding port is 0.

## Timing
- Request path is combinational: req_i → mem_req_o/mem_* in the same cycle. Grant is mem_gnt_i → *_gnt_o in the same cycle.
- Response path is combinational: mem_rvalid_i → *_rvalid_o/rdata_o in the same cycle, using the registered FIFO head.
- Downstream must return rvalid at least 1 cycle after gnt. A grant and its own response are never in the same cycle.
- Reset (async assert, sync-released flops) clears all state:
  - state=IDLE, FIFO empty, count=0, last_grant=instr, err_o=0.
  - Outputs: mem_req_o=0, both gnt_o=0, both rvalid_o=0, rdata_o=0, outstanding_o=0.
- Reset mid-transaction discards all outstanding IDs. Responses arriving after reset with count 0 set err_o.

## Test plan
- Data only, 1-cycle gnt, 1-cycle rvalid, 4 back-to-back reads at 0x100..0x10C:
  - data_gnt_o each cycle.
  - data_rvalid_o follows one cycle after each grant, carrying 0x100..0x10C memory data.
  - instr_gnt_o and instr_rvalid_o stay 0.
- Both requesting continuously with mem_gnt_i=1:
  - Grants alternate data, instr, data, instr starting with data.
  - mem_we_o=0 and mem_be_o=4'hF on the instr cycles.
- Data requests, mem_gnt_i held 0 for 3 cycles, instr raises req in cycle 1:
  - mem_addr_o stays the data address for all 3 cycles.
  - Data granted in cycle 4, then instr.
- MAX_OUTSTANDING=2, rvalid delayed 5 cycles:
  - Two grants, then mem_req_o=0 until the first rvalid.
  - Responses return in grant order (instr then data) to the correct ports.
  - outstanding_o goes 1, 2, 1, ….
- Reset asserted with 2 outstanding, then a stray mem_rvalid_i=1 after release:
  - All outputs return to reset values immediately.
  - Neither rvalid_o asserts on the stray response; err_o=1 and stays 1.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: round-robin 2:1 OBI arbiter, instr + data onto one mem port.
// Ports: instr_* / data_* upstream, mem_* downstream, outstanding_o count, err_o sticky.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            instr_req_i,
  input  logic [ADDR_WIDTH-1:0]           instr_addr_i,
  output logic                            instr_gnt_o,
  output logic                            instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]           instr_rdata_o,
  input  logic                            data_req_i,
  input  logic [ADDR_WIDTH-1:0]           data_addr_i,
  input  logic                            data_we_i,
  input  logic [DATA_WIDTH/8-1:0]         data_be_i,
  input  logic [DATA_WIDTH-1:0]           data_wdata_i,
  output logic                            data_gnt_o,
  output logic                            data_rvalid_o,
  output logic [DATA_WIDTH-1:0]           data_rdata_o,
  output logic                            mem_req_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic                            mem_we_o,
  output logic [DATA_WIDTH/8-1:0]         mem_be_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                            err_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  // Port IDs: 0 = instr, 1 = data
  state_t        r_state;
  logic          r_sel;
  logic          r_last;
  logic          r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic w_full;
  logic w_pick;
  logic w_req;
  logic w_sel;
  logic w_acc;
  logic w_pop;
  logic w_head;

  assign w_full = (r_cnt == MAXC);

  // On conflict the port not granted last wins
  assign w_pick = (instr_req_i & data_req_i) ?
                  ~r_last : data_req_i;

  assign w_req = (r_state == LOCKED) |
                 (~w_full & (instr_req_i | data_req_i));

  assign w_sel = (r_state == LOCKED) ? r_sel : w_pick;
  assign w_acc = w_req & mem_gnt_i;
  assign w_pop = mem_rvalid_i & (r_cnt != '0);
  assign w_head = r_fifo[r_rptr];

  always_comb begin
    mem_req_o   = w_req;
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = {BW{1'b1}};
    mem_wdata_o = '0;
    if (w_sel) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = w_acc & ~w_sel;
  assign data_gnt_o  = w_acc & w_sel;

  assign instr_rvalid_o = w_pop & ~w_head;
  assign data_rvalid_o  = w_pop & w_head;
  assign instr_rdata_o  = instr_rvalid_o ?
                          mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ?
                          mem_rdata_i : '0;

  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        r_fifo[i] <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req && !mem_gnt_i) begin
            r_state <= LOCKED;
            r_sel   <= w_sel;
          end
        end
        LOCKED: begin
          if (mem_gnt_i)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_acc) begin
        r_fifo[r_wptr] <= w_sel;
        r_last         <= w_sel;
        r_wptr <= (r_wptr == LASTP) ?
                  '0 : r_wptr + 1'b1;
      end

      if (w_pop)
        r_rptr <= (r_rptr == LASTP) ?
                  '0 : r_rptr + 1'b1;

      unique case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      if (mem_rvalid_i && r_cnt == '0)
        r_err <= 1'b1;
    end
  end

endmodule
